// File: rtl/game_pkg.sv
// Shared definitions for the game datapath.
//   - 2-bit game-state encodings driven by the top-level game state machine
//   - controller state enum used by game_tick_controller
//   - score width, level width, gap counter width/reload base, LFSR seed
//   - lfsr_next(): one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package game_pkg;

  localparam logic [1:0] S_START        = 2'b00;
  localparam logic [1:0] S_PLAYING      = 2'b01;
  localparam logic [1:0] S_INSTRUCTIONS = 2'b10;
  localparam logic [1:0] S_GAME_OVER    = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFreeze
  } ctrl_state_e;

  localparam int unsigned ScoreW = 14;
  localparam int unsigned LevelW = 3;

  // Gap counter reloads 4..11, so 4 bits suffice.
  localparam int unsigned       GapW    = 4;
  localparam logic [GapW-1:0]   GapInit = 4'd4;

  localparam logic [7:0] LfsrSeed = 8'hA5;

  // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-Div counter with synchronous clear and count enable.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   clear_i   force count to 0 (wins over enable_i)
//   enable_i  advance the count this cycle
//   wrap_o    combinational: high in the enabled cycle where the count is Div-1
module tick_prescaler #(
  parameter int unsigned Div = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic wrap_o
);

  localparam int unsigned       CntW    = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap_o = enable_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_tick_controller.sv
// Playing-phase sequencer: follows the game state word and produces the frame,
// obstacle-move and obstacle-spawn strobes, plus score, level and high score.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   state       game state (00 START, 01 PLAYING, 10 INSTRUCTIONS, 11 GAME_OVER)
//   collision   collision detector output
//   frame_tick  one-cycle pulse per frame while running
//   move_tick   one-cycle pulse: obstacles advance one step
//   spawn_req   one-cycle pulse: spawn an obstacle (only together with move_tick)
//   score       current score, saturating at SCORE_MAX
//   level       difficulty level, saturating at MAX_LEVEL
//   high_score  best score since reset
// Build option: define GAME_HIGH_SCORE_EN to build the high-score register;
// otherwise high_score is tied to 0.
module game_tick_controller
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 833333,
  parameter int unsigned MOVE_BASE  = 8,
  parameter int unsigned LEVEL_STEP = 100,
  parameter int unsigned MAX_LEVEL  = 7,
  parameter int unsigned SCORE_MAX  = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        state,
  input  logic              collision,
  output logic              frame_tick,
  output logic              move_tick,
  output logic              spawn_req,
  output logic [ScoreW-1:0] score,
  output logic [LevelW-1:0] level,
  output logic [ScoreW-1:0] high_score
);

  localparam int unsigned FrameW = $clog2(MOVE_BASE + 1);
  localparam int unsigned PtsW   = $clog2(LEVEL_STEP + 1);

  localparam logic [FrameW-1:0] FrameLast = FrameW'(MOVE_BASE - 1);
  localparam logic [PtsW-1:0]   PtsStep   = PtsW'(LEVEL_STEP);
  localparam logic [ScoreW-1:0] ScoreMax  = ScoreW'(SCORE_MAX);
  localparam logic [LevelW-1:0] LevelMax  = LevelW'(MAX_LEVEL);

  ctrl_state_e ctrl_q, ctrl_d;
  logic        enter_run;  // full clear of the play counters this cycle
  logic        stay_run;   // RUN and remaining in RUN: the only cycles that count

  logic [FrameW-1:0] frame_q, frame_d, frame_target;
  logic [GapW-1:0]   gap_q, gap_d, gap_reload;
  logic [PtsW-1:0]   pts_q, pts_d;
  logic [ScoreW-1:0] score_q, score_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [7:0]        lfsr_q;
  logic              frame_tick_q, move_tick_q, spawn_req_q;

  logic frame_wrap, move_due, spawn_due, score_inc, level_up;

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d    = ctrl_q;
    enter_run = 1'b0;
    stay_run  = 1'b0;
    unique case (ctrl_q)
      StIdle: begin
        if (state == S_PLAYING) begin
          ctrl_d    = StRun;
          enter_run = 1'b1;
        end
      end
      StRun: begin
        // collision freezes at once, covering the state machine's one-cycle lag
        if ((state == S_GAME_OVER) || collision) begin
          ctrl_d = StFreeze;
        end else if (state == S_PLAYING) begin
          stay_run = 1'b1;
        end else begin
          ctrl_d = StIdle;
        end
      end
      StFreeze: begin
        if ((state == S_START) || (state == S_INSTRUCTIONS)) begin
          ctrl_d = StIdle;
        end else if ((state == S_PLAYING) && !collision) begin
          ctrl_d    = StRun;
          enter_run = 1'b1;
        end
      end
      default: ctrl_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame prescaler: held at 0 whenever the game is not actively running
  // ---------------------------------------------------------------------------
  tick_prescaler #(
    .Div(TICK_DIV)
  ) u_frame_prescaler (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (~stay_run),
    .enable_i(stay_run),
    .wrap_o  (frame_wrap)
  );

  // Higher level shortens the move period by one frame per level.
  assign frame_target = FrameLast - FrameW'(level_q);
  assign gap_reload   = GapInit + {1'b0, lfsr_q[2:0]};

  assign move_due  = stay_run && frame_wrap && (frame_q == frame_target);
  assign spawn_due = move_due && (gap_q == GapW'(1));
  assign score_inc = move_due && (score_q < ScoreMax);
  assign level_up  = stay_run && (pts_q == PtsStep);

  // ---------------------------------------------------------------------------
  // Play counters
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_d = frame_q;
    gap_d   = gap_q;
    pts_d   = pts_q;
    score_d = score_q;
    level_d = level_q;

    if (!stay_run) begin
      frame_d = '0;
    end else if (frame_wrap) begin
      frame_d = move_due ? '0 : frame_q + FrameW'(1);
    end

    if (enter_run) begin
      gap_d = GapInit;
    end else if (ctrl_q == StIdle) begin
      gap_d = '0;
    end else if (move_due) begin
      gap_d = spawn_due ? gap_reload : gap_q - GapW'(1);
    end

    if (enter_run) begin
      score_d = '0;
    end else if (score_inc) begin
      score_d = score_q + ScoreW'(1);
    end

    // Points only accrue while the score actually grows.
    if (enter_run) begin
      pts_d = '0;
    end else if (level_up) begin
      pts_d = score_inc ? PtsW'(1) : '0;
    end else if (score_inc) begin
      pts_d = pts_q + PtsW'(1);
    end

    if (enter_run) begin
      level_d = '0;
    end else if (level_up && (level_q < LevelMax)) begin
      level_d = level_q + LevelW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= StIdle;
      frame_q      <= '0;
      gap_q        <= '0;
      pts_q        <= '0;
      score_q      <= '0;
      level_q      <= '0;
      lfsr_q       <= LfsrSeed;
      frame_tick_q <= 1'b0;
      move_tick_q  <= 1'b0;
      spawn_req_q  <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      frame_q      <= frame_d;
      gap_q        <= gap_d;
      pts_q        <= pts_d;
      score_q      <= score_d;
      level_q      <= level_d;
      // free-running in every state so spawn gaps depend on menu timing
      lfsr_q       <= lfsr_next(lfsr_q);
      frame_tick_q <= stay_run && frame_wrap;
      move_tick_q  <= move_due;
      spawn_req_q  <= spawn_due;
    end
  end

  // ---------------------------------------------------------------------------
  // High score
  // ---------------------------------------------------------------------------
`ifdef GAME_HIGH_SCORE_EN
  logic [ScoreW-1:0] high_q, high_d;

  always_comb begin
    high_d = high_q;
    if ((ctrl_q == StRun) && (ctrl_d == StFreeze) && (score_q > high_q)) begin
      high_d = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_q <= '0;
    end else begin
      high_q <= high_d;
    end
  end

  assign high_score = high_q;
`else
  assign high_score = '0;
`endif

  assign frame_tick = frame_tick_q;
  assign move_tick  = move_tick_q;
  assign spawn_req  = spawn_req_q;
  assign score      = score_q;
  assign level      = level_q;

endmodule

// File: tb/tb_game_tick_controller.sv
// Bench for game_tick_controller: hand-derived vector table for the directed
// corner cases, then randomized state/collision/reset traffic. Every cycle the
// DUT outputs are compared with a behavioural model of the game rules.
module tb_game_tick_controller;

  localparam int TickDiv   = 4;
  localparam int MoveBase  = 4;
  localparam int LevelStep = 3;
  localparam int MaxLevel  = 1;
  localparam int ScoreMax  = 6;
`ifdef GAME_HIGH_SCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  state = 2'b01;
  logic        collision = 1'b0;
  logic        frame_tick, move_tick, spawn_req;
  logic [13:0] score, high_score;
  logic [2:0]  level;

  game_tick_controller #(
    .TICK_DIV  (TickDiv),
    .MOVE_BASE (MoveBase),
    .LEVEL_STEP(LevelStep),
    .MAX_LEVEL (MaxLevel),
    .SCORE_MAX (ScoreMax)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .collision (collision),
    .frame_tick(frame_tick),
    .move_tick (move_tick),
    .spawn_req (spawn_req),
    .score     (score),
    .level     (level),
    .high_score(high_score)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nbad = 0;

  // ---------------------------------------------------------------------------
  // Reference model of the game rules
  // ---------------------------------------------------------------------------
  localparam int MIdle = 0, MRun = 1, MFreeze = 2;

  int     m_mode = MIdle;
  int     m_cyc_in_frame = 0;  // cycles elapsed in the current frame
  int     m_frames = 0;        // frames completed since the last move
  int     m_gap = 0;           // moves left until the next spawn
  int     m_pts = 0;
  int     m_score = 0;
  int     m_level = 0;
  int     m_high = 0;
  bit [7:0] m_lfsr = 8'hA5;
  bit     e_frame = 1'b0, e_move = 1'b0, e_spawn = 1'b0;

  function automatic bit [7:0] ref_lfsr(input bit [7:0] v);
    int taps[4] = '{8, 6, 5, 4};
    bit fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[6:0], fb};
  endfunction

  task automatic start_game();
    m_mode = MRun;
    m_score = 0;
    m_level = 0;
    m_pts = 0;
    m_cyc_in_frame = 0;
    m_frames = 0;
    m_gap = 4;
  endtask

  task automatic go_idle();
    m_mode = MIdle;
    m_cyc_in_frame = 0;
    m_frames = 0;
    m_gap = 0;
  endtask

  task automatic run_one_cycle();
    int  lv = m_level;
    bit  up = (m_pts == LevelStep);
    m_cyc_in_frame++;
    if (m_cyc_in_frame == TickDiv) begin
      m_cyc_in_frame = 0;
      e_frame = 1'b1;
      m_frames++;
      if (m_frames == MoveBase - lv) begin
        m_frames = 0;
        e_move = 1'b1;
        m_gap--;
        if (m_gap == 0) begin
          e_spawn = 1'b1;
          m_gap = 4 + int'(m_lfsr & 8'h07);
        end
        if (m_score < ScoreMax) begin
          m_score++;
          m_pts++;
        end
      end
    end
    if (up) begin
      m_pts -= LevelStep;
      if (m_level < MaxLevel) m_level++;
    end
  endtask

  task automatic model_step();
    e_frame = 1'b0;
    e_move  = 1'b0;
    e_spawn = 1'b0;
    if (rst) begin
      go_idle();
      m_score = 0;
      m_level = 0;
      m_pts = 0;
      m_high = 0;
      m_lfsr = 8'hA5;
    end else begin
      case (m_mode)
        MIdle: if (state == 2'b01) start_game();
        MRun: begin
          if (state == 2'b11 || collision) begin
            if (HsEn && m_score > m_high) m_high = m_score;
            m_mode = MFreeze;
          end else if (state != 2'b01) begin
            go_idle();
          end else begin
            run_one_cycle();
          end
        end
        default: begin
          if (state == 2'b00 || state == 2'b10) go_idle();
          else if (state == 2'b01 && !collision) start_game();
        end
      endcase
      m_lfsr = ref_lfsr(m_lfsr);
    end
  endtask

  task automatic check_model();
    nchk++;
    if (frame_tick !== e_frame || move_tick !== e_move || spawn_req !== e_spawn ||
        score !== 14'(m_score) || level !== 3'(m_level) || high_score !== 14'(m_high)) begin
      nbad++;
      $display("FAIL model t=%0t got f=%0b m=%0b s=%0b score=%0d lvl=%0d hi=%0d want f=%0b m=%0b s=%0b score=%0d lvl=%0d hi=%0d",
               $time, frame_tick, move_tick, spawn_req, score, level, high_score,
               e_frame, e_move, e_spawn, m_score, m_level, m_high);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs held for n cycles, then outputs compared
  // ---------------------------------------------------------------------------
  typedef struct {
    bit       rst;
    bit [1:0] st;
    bit       col;
    int       n;
    bit       f;
    bit       m;
    bit       sp;
    int       sc;
    int       lv;
    int       hi;
  } vec_t;

  function automatic vec_t mk(bit r, bit [1:0] s, bit c, int n, bit f, bit m, bit sp,
                              int sc, int lv, int hi);
    vec_t v;
    v.rst = r; v.st = s; v.col = c; v.n = n;
    v.f = f; v.m = m; v.sp = sp; v.sc = sc; v.lv = lv; v.hi = hi;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   hs5;
    hs5 = HsEn ? 5 : 0;

    tbl.push_back(mk(1, 2'b01, 0,   2, 0, 0, 0, 0, 0, 0));   // reset while PLAYING
    tbl.push_back(mk(0, 2'b01, 0,   4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0,   1, 1, 0, 0, 0, 0, 0));   // first frame 5 cycles in
    tbl.push_back(mk(0, 2'b01, 0,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0,  11, 1, 1, 0, 1, 0, 0));   // move every 16 at level 0
    tbl.push_back(mk(0, 2'b01, 0,  16, 1, 1, 0, 2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0,  16, 1, 1, 0, 3, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0,   1, 0, 0, 0, 3, 1, 0));   // level follows a cycle later
    tbl.push_back(mk(0, 2'b01, 0,  11, 1, 1, 1, 4, 1, 0));   // 12-cycle period, 1st spawn
    tbl.push_back(mk(0, 2'b01, 0,  12, 1, 1, 0, 5, 1, 0));
    tbl.push_back(mk(0, 2'b01, 0,  11, 0, 0, 0, 5, 1, 0));   // move is decoded now
    tbl.push_back(mk(0, 2'b01, 1,   1, 0, 0, 0, 5, 1, hs5)); // collision swallows it
    tbl.push_back(mk(0, 2'b11, 0,   1, 0, 0, 0, 5, 1, hs5));
    tbl.push_back(mk(0, 2'b11, 0,   8, 0, 0, 0, 5, 1, hs5));
    tbl.push_back(mk(0, 2'b01, 0,   1, 0, 0, 0, 0, 0, hs5)); // new game clears
    tbl.push_back(mk(0, 2'b01, 0,  16, 1, 1, 0, 1, 0, hs5));
    tbl.push_back(mk(0, 2'b01, 0,  16, 1, 1, 0, 2, 0, hs5));
    tbl.push_back(mk(0, 2'b01, 1,   1, 0, 0, 0, 2, 0, hs5)); // lower score keeps high
    tbl.push_back(mk(0, 2'b11, 0,   2, 0, 0, 0, 2, 0, hs5));
    tbl.push_back(mk(0, 2'b00, 0,   1, 0, 0, 0, 2, 0, hs5)); // menu shows last game
    tbl.push_back(mk(1, 2'b00, 0,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0,   1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 134, 0, 0, 0, 6, 1, 0));   // 10 moves: both saturated

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      state = tbl[i].st;
      collision = tbl[i].col;
      repeat (tbl[i].n) tick();
      nchk++;
      if (frame_tick !== tbl[i].f || move_tick !== tbl[i].m || spawn_req !== tbl[i].sp ||
          score !== 14'(tbl[i].sc) || level !== 3'(tbl[i].lv) ||
          high_score !== 14'(tbl[i].hi)) begin
        nbad++;
        $display("FAIL vec%0d got f=%0b m=%0b s=%0b score=%0d lvl=%0d hi=%0d want f=%0b m=%0b s=%0b score=%0d lvl=%0d hi=%0d",
                 i, frame_tick, move_tick, spawn_req, score, level, high_score,
                 tbl[i].f, tbl[i].m, tbl[i].sp, tbl[i].sc, tbl[i].lv, tbl[i].hi);
      end
    end

    // Randomized segments of held game state with sparse collisions and resets.
    for (int seg = 0; seg < 120; seg++) begin
      int r;
      int len;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        state = 2'b01;
        len = $urandom_range(20, 150);
      end else begin
        state = (r < 75) ? 2'b11 : (r < 90) ? 2'b00 : 2'b10;
        len = $urandom_range(1, 30);
      end
      for (int k = 0; k < len; k++) begin
        collision = ($urandom_range(0, 79) == 0);
        rst = ($urandom_range(0, 999) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
